// File: rtl/spi_target_core.sv
// ---------------------------------------------------------------------------
// spi_target_core
//
// SPI target (slave) for the link driven by the team's SCLK generator. SCLK,
// CS_N and MOSI are oversampled in the i_clk domain. The core supports all
// four CPOL/CPHA modes and a per-frame word length. Received words are
// presented on o_rx_data with a one-cycle o_rx_valid pulse. Words to send
// come from a one-entry holding register, which is written with a
// valid/ready handshake.
//
// Optional build feature:
//   SPI_TGT_LSB_FIRST_EN  adds input i_lsb_first, which selects LSB-first
//                         shifting. It is latched when CS falls.
//
// Ports:
//   i_clk, i_rst          system clock, asynchronous active-high reset
//   i_cpol, i_cpha        SPI mode, latched when CS falls
//   i_frame_len           bits per word (0 or > MAX_W means MAX_W)
//   i_sclk, i_cs_n, i_mosi  asynchronous SPI pins from the initiator
//   o_miso, o_miso_oe     serial data out and its output enable
//   i_tx_data, i_tx_valid, o_tx_ready   TX holding-register write handshake
//   o_tx_underrun         pulse: a word load found the holding register empty
//   o_rx_data, o_rx_valid last complete word (right-aligned) and update pulse
//   o_frame_err           pulse: CS rose in the middle of a word
// ---------------------------------------------------------------------------
module spi_target_core #(
  parameter int MAX_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic [5:0]       i_frame_len,
  input  logic             i_sclk,
  input  logic             i_cs_n,
  input  logic             i_mosi,
`ifdef SPI_TGT_LSB_FIRST_EN
  input  logic             i_lsb_first,
`endif
  output logic             o_miso,
  output logic             o_miso_oe,
  input  logic [MAX_W-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic             o_tx_underrun,
  output logic [MAX_W-1:0] o_rx_data,
  output logic             o_rx_valid,
  output logic             o_frame_err
);

  localparam logic [6:0] MAX_LEN = 7'(MAX_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic sclk_meta, sclk_s, sclk_d;
  logic cs_meta, cs_s;
  logic mosi_meta, mosi_s;

  logic cpol_l, cpha_l, lsb_l, lsb_sel;
  logic [6:0] len_l, len_in, load_len;
  logic [6:0] bit_cnt;
  logic first;

  logic lead_edge, trail_edge, sample_now, shift_now;
  logic sample_evt, shift_evt, mosi_evt;

  logic start_frame, end_frame, active_run, word_done, load_now, load_lsb;

  logic [MAX_W-1:0] rx_shift, rx_in, rx_mask, rx_word, mosi_bit;
  logic [MAX_W-1:0] tx_shift, tx_hold, load_word, load_shift;
  logic tx_full;

`ifdef SPI_TGT_LSB_FIRST_EN
  assign lsb_sel = i_lsb_first;
`else
  assign lsb_sel = 1'b0;
`endif

  // Two-flop synchronizers on the asynchronous pins. sclk_d keeps the
  // previous synchronized SCLK level so that edges can be detected.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_meta <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_d    <= 1'b0;
      cs_meta   <= 1'b1;
      cs_s      <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      sclk_meta <= i_sclk;
      sclk_s    <= sclk_meta;
      sclk_d    <= sclk_s;
      cs_meta   <= i_cs_n;
      cs_s      <= cs_meta;
      mosi_meta <= i_mosi;
      mosi_s    <= mosi_meta;
    end
  end

  // Leading and trailing edges are defined relative to the latched idle
  // level. CPHA selects which of the two edges samples MOSI; the other
  // edge shifts MISO.
  always_comb begin
    lead_edge  = (sclk_d == cpol_l) && (sclk_s != cpol_l);
    trail_edge = (sclk_d != cpol_l) && (sclk_s == cpol_l);
    sample_now = cpha_l ? trail_edge : lead_edge;
    shift_now  = cpha_l ? lead_edge  : trail_edge;
  end

  // Edge-event register. MOSI is captured in the same cycle as its edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sample_evt <= 1'b0;
      shift_evt  <= 1'b0;
      mosi_evt   <= 1'b0;
    end else begin
      sample_evt <= (state_q == ACTIVE) && sample_now;
      shift_evt  <= (state_q == ACTIVE) && shift_now;
      mosi_evt   <= mosi_s;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Frame start and end come from the synchronized chip select only. SCLK
  // edges have no effect in IDLE.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d     = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_d   = IDLE;
          end_frame = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word length, word completion, and the data presented to the holding
  // register and shifters. In MSB-first mode the TX word is left-aligned,
  // so MISO always comes from the top bit whatever the length.
  always_comb begin
    len_in     = ((i_frame_len == 6'd0) || ({1'b0, i_frame_len} > MAX_LEN))
                 ? MAX_LEN : {1'b0, i_frame_len};
    active_run = (state_q == ACTIVE) && !cs_s;
    word_done  = active_run && sample_evt && (bit_cnt == (len_l - 7'd1));
    load_now   = start_frame || word_done;
    load_len   = start_frame ? len_in : len_l;
    load_lsb   = start_frame ? lsb_sel : lsb_l;
    load_word  = tx_full ? tx_hold : {MAX_W{1'b1}};
    load_shift = load_lsb ? load_word : (load_word << (MAX_LEN - load_len));

    mosi_bit   = {{(MAX_W-1){1'b0}}, mosi_evt} << (len_l - 7'd1);
    rx_in      = lsb_l ? ((rx_shift >> 1) | mosi_bit)
                       : {rx_shift[MAX_W-2:0], mosi_evt};
    rx_mask    = ~({MAX_W{1'b1}} << len_l);
    rx_word    = rx_in & rx_mask;
  end

  // Receive path, bit counter and frame-level status. The frame
  // configuration is captured only when CS falls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cpol_l      <= 1'b0;
      cpha_l      <= 1'b0;
      lsb_l       <= 1'b0;
      len_l       <= MAX_LEN;
      bit_cnt     <= 7'd0;
      first       <= 1'b1;
      rx_shift    <= '0;
      o_rx_data   <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      if (start_frame) begin
        cpol_l   <= i_cpol;
        cpha_l   <= i_cpha;
        lsb_l    <= lsb_sel;
        len_l    <= len_in;
        bit_cnt  <= 7'd0;
        first    <= 1'b1;
        rx_shift <= '0;
      end
      if (end_frame && (bit_cnt != 7'd0))
        o_frame_err <= 1'b1;
      if (active_run && sample_evt) begin
        if (word_done) begin
          o_rx_data  <= rx_word;
          o_rx_valid <= 1'b1;
          bit_cnt    <= 7'd0;
          first      <= 1'b1;
          rx_shift   <= '0;
        end else begin
          rx_shift <= rx_in;
          bit_cnt  <= bit_cnt + 7'd1;
          first    <= 1'b0;
        end
      end
    end
  end

  // TX shifter and holding register. A word load takes priority over a
  // shift. The shift edge that comes right after a load (or after CS falls)
  // is skipped so that the first bit stays on MISO. When a load and a write
  // happen in the same cycle, the load sees the old (empty) holding state
  // and the written word stays in the holding register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_shift      <= '0;
      tx_hold       <= '0;
      tx_full       <= 1'b0;
      o_tx_underrun <= 1'b0;
    end else begin
      o_tx_underrun <= 1'b0;
      if (load_now)
        tx_shift <= load_shift;
      else if (active_run && shift_evt && !first)
        tx_shift <= lsb_l ? (tx_shift >> 1) : (tx_shift << 1);
      if (load_now) begin
        if (tx_full) tx_full       <= 1'b0;
        else         o_tx_underrun <= 1'b1;
      end
      if (i_tx_valid && !tx_full) begin
        tx_hold <= i_tx_data;
        tx_full <= 1'b1;
      end
    end
  end

  assign o_miso     = lsb_l ? tx_shift[0] : tx_shift[MAX_W-1];
  assign o_miso_oe  = ~cs_s;
  assign o_tx_ready = ~tx_full;

endmodule

// File: tb/tb_spi_target_core.sv
// ---------------------------------------------------------------------------
// tb_spi_target_core
//
// Self-checking bench for spi_target_core. A table of single-word frames is
// run in every SPI mode and at several word lengths. Hand-written sequences
// then cover back-to-back words, an abandoned frame and (in the LSB-first
// build) LSB-first order. Expected RX words are queued when a frame is
// driven and popped whenever o_rx_valid pulses.
// ---------------------------------------------------------------------------
module tb_spi_target_core;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpol, cpha;
  logic [5:0]  frame_len;
  logic        sclk, cs_n, mosi;
`ifdef SPI_TGT_LSB_FIRST_EN
  logic        lsb_first;
`endif
  logic        miso, miso_oe;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready, tx_underrun;
  logic [31:0] rx_data;
  logic        rx_valid, frame_err;

  int checks   = 0;
  int failures = 0;
  int und_cnt  = 0;
  int ferr_cnt = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_exp = 32'h0;

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [5:0]  flen;
    logic        preload;
    logic [31:0] tx;
    logic [31:0] mosi;
    logic [31:0] exp_rx;
    logic [31:0] exp_miso;
    int          exp_und;
  } vec_t;

  vec_t vecs [0:6];

  spi_target_core #(.MAX_W(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cpol       (cpol),
    .i_cpha       (cpha),
    .i_frame_len  (frame_len),
    .i_sclk       (sclk),
    .i_cs_n       (cs_n),
    .i_mosi       (mosi),
`ifdef SPI_TGT_LSB_FIRST_EN
    .i_lsb_first  (lsb_first),
`endif
    .o_miso       (miso),
    .o_miso_oe    (miso_oe),
    .i_tx_data    (tx_data),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .o_tx_underrun(tx_underrun),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .o_frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Scoreboard and pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL rx_valid_unexpected rx_data=%h expected no pulse", rx_data);
        end else begin
          last_exp = sb_q.pop_front();
          if (rx_data !== last_exp) begin
            failures++;
            $display("[TB] FAIL rx_word got=%h expected=%h", rx_data, last_exp);
          end
        end
      end
      if (tx_underrun) und_cnt++;
      if (frame_err)   ferr_cnt++;
    end
  end

  // Stops the run if something hangs.
  initial begin
    #600us;
    $display("[TB] FAIL watchdog_timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic writeTx(input logic [31:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic csLow(input logic pol);
    sclk = pol;
    waitClk(6);
    cs_n = 1'b0;
    waitClk(8);
    checkOutput("miso_oe_active", {31'b0, miso_oe}, 32'd1);
  endtask

  task automatic csHigh();
    cs_n = 1'b1;
    waitClk(8);
    checkOutput("miso_oe_idle", {31'b0, miso_oe}, 32'd0);
  endtask

  // Drives nbits of one word and collects the MISO bit seen at each sample
  // edge. The expected RX word is queued only when the word is complete.
  task automatic spiXfer(input logic pol, input logic pha, input int len, input int nbits,
                         input logic lsb, input logic [31:0] mword, input logic [31:0] exp_rx,
                         output logic [31:0] miso_word);
    logic b, mb;
    int idx;
    miso_word = 32'h0;
    if (nbits == len) sb_q.push_back(exp_rx);
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : len - 1 - i;
      b = mword[idx];
      if (!pha) begin
        mosi = b;
        waitClk(H);
        mb = miso;
        sclk = ~pol;
        waitClk(H);
        sclk = pol;
      end else begin
        waitClk(H);
        sclk = ~pol;
        mosi = b;
        waitClk(H);
        mb = miso;
        sclk = pol;
      end
      if (lsb) miso_word[i] = mb;
      else     miso_word = {miso_word[30:0], mb};
    end
    waitClk(H);
  endtask

  // Runs one table entry as a complete single-word frame.
  task automatic applyStimulus(input vec_t v, input int id);
    int eff, u0, f0;
    logic [31:0] mw;
    eff = (v.flen == 6'd0 || v.flen > 6'd32) ? 32 : int'(v.flen);
    if (v.preload) writeTx(v.tx);
    cpol = v.cpol;
    cpha = v.cpha;
    frame_len = v.flen;
    u0 = und_cnt;
    f0 = ferr_cnt;
    csLow(v.cpol);
    spiXfer(v.cpol, v.cpha, eff, eff, 1'b0, v.mosi, v.exp_rx, mw);
    csHigh();
    $display("[TB] vector %0d done", id);
    checkOutput("vec_miso", mw, v.exp_miso);
    checkOutput("vec_rx_data", rx_data, v.exp_rx);
    checkOutput("vec_sb_drained", sb_q.size(), 32'd0);
    checkOutput("vec_underrun", und_cnt - u0, v.exp_und);
    checkOutput("vec_frame_err", ferr_cnt - f0, 32'd0);
    checkOutput("vec_tx_ready", {31'b0, tx_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] m1, m2;
    int u0, f0;

    vecs[0] = '{1'b0, 1'b0, 6'd8,  1'b1, 32'hA5,       32'h3C,       32'h3C,       32'hA5,       1};
    vecs[1] = '{1'b1, 1'b1, 6'd16, 1'b1, 32'h1234,     32'hBEEF,     32'hBEEF,     32'h1234,     1};
    vecs[2] = '{1'b0, 1'b1, 6'd5,  1'b1, 32'h13,       32'h0A,       32'h0A,       32'h13,       1};
    vecs[3] = '{1'b1, 1'b0, 6'd0,  1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'hCAFEF00D, 32'hDEADBEEF, 1};
    vecs[4] = '{1'b0, 1'b0, 6'd8,  1'b0, 32'h0,        32'h5A,       32'h5A,       32'hFF,       2};
    vecs[5] = '{1'b0, 1'b0, 6'd40, 1'b1, 32'h80000001, 32'h12345678, 32'h12345678, 32'h80000001, 1};
    vecs[6] = '{1'b0, 1'b0, 6'd3,  1'b1, 32'hFD,       32'hFE,       32'h6,        32'h5,        1};

    rst = 1'b1;
    cpol = 1'b0;
    cpha = 1'b0;
    frame_len = 6'd8;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
`ifdef SPI_TGT_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    tx_data = 32'h0;
    tx_valid = 1'b0;
    waitClk(3);
    checkOutput("rst_miso",      {31'b0, miso},        32'd0);
    checkOutput("rst_miso_oe",   {31'b0, miso_oe},     32'd0);
    checkOutput("rst_tx_ready",  {31'b0, tx_ready},    32'd1);
    checkOutput("rst_underrun",  {31'b0, tx_underrun}, 32'd0);
    checkOutput("rst_rx_data",   rx_data,              32'd0);
    checkOutput("rst_rx_valid",  {31'b0, rx_valid},    32'd0);
    checkOutput("rst_frame_err", {31'b0, frame_err},   32'd0);
    rst = 1'b0;
    waitClk(4);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // Back-to-back words in mode 1 under one CS. The write of 0x99 happens
    // while the holding register is full, so it must be ignored.
    writeTx(32'h81);
    writeTx(32'h99);
    cpol = 1'b0;
    cpha = 1'b1;
    frame_len = 6'd8;
    u0 = und_cnt;
    f0 = ferr_cnt;
    csLow(1'b0);
    fork
      begin
        spiXfer(1'b0, 1'b1, 8, 8, 1'b0, 32'h11, 32'h11, m1);
        spiXfer(1'b0, 1'b1, 8, 8, 1'b0, 32'h22, 32'h22, m2);
      end
      begin
        waitClk(20);
        writeTx(32'h7E);
        for (int k = 0; k < 400 && !tx_ready; k++) @(negedge clk);
        checkOutput("b2b_ready_wait", {31'b0, tx_ready}, 32'd1);
        waitClk(20);
        writeTx(32'h00);
      end
    join
    csHigh();
    checkOutput("b2b_miso_w1",   m1, 32'h81);
    checkOutput("b2b_miso_w2",   m2, 32'h7E);
    checkOutput("b2b_sb_drained", sb_q.size(), 32'd0);
    checkOutput("b2b_underrun",  und_cnt - u0, 32'd0);
    checkOutput("b2b_frame_err", ferr_cnt - f0, 32'd0);
    checkOutput("b2b_rx_data",   rx_data, 32'h22);

    // CS rises after 5 of 8 bits: the partial word is discarded.
    writeTx(32'h55);
    cpol = 1'b0;
    cpha = 1'b0;
    frame_len = 6'd8;
    u0 = und_cnt;
    f0 = ferr_cnt;
    csLow(1'b0);
    spiXfer(1'b0, 1'b0, 8, 5, 1'b0, 32'hFF, 32'h0, m1);
    csHigh();
    checkOutput("ferr_pulse",    ferr_cnt - f0, 32'd1);
    checkOutput("ferr_rx_kept",  rx_data, last_exp);
    checkOutput("ferr_rx_kept2", rx_data, 32'h22);
    checkOutput("ferr_underrun", und_cnt - u0, 32'd0);
    checkOutput("ferr_sb_empty", sb_q.size(), 32'd0);
    checkOutput("ferr_tx_ready", {31'b0, tx_ready}, 32'd1);

    // A clean frame after the error must work normally.
    applyStimulus(vecs[0], 7);

`ifdef SPI_TGT_LSB_FIRST_EN
    // LSB-first order: MOSI 0x01 is sent bit 0 first; TX 0x80 is returned
    // bit 0 first.
    lsb_first = 1'b1;
    writeTx(32'h80);
    cpol = 1'b0;
    cpha = 1'b0;
    frame_len = 6'd8;
    csLow(1'b0);
    lsb_first = 1'b0;
    spiXfer(1'b0, 1'b0, 8, 8, 1'b1, 32'h01, 32'h01, m1);
    csHigh();
    checkOutput("lsb_rx_data", rx_data, 32'h01);
    checkOutput("lsb_miso",    m1, 32'h80);
    checkOutput("lsb_sb_drained", sb_q.size(), 32'd0);
`endif

    waitClk(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
